// File: rtl/multi_road_light_ctrl.sv
// multi_road_light_ctrl: N-road intersection sequencer, one green at a time,
// with demand skipping, gap-out, all-red clearance and a countdown output.
module multi_road_light_ctrl #(
  parameter int NUM_ROADS = 2,
  parameter int TIME_W    = 6,
  parameter int ALL_RED_T = 1,
  parameter int MIN_GREEN = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [NUM_ROADS-1:0]         car,
  input  logic [TIME_W-1:0]            green_time,
  input  logic [TIME_W-1:0]            yellow_time,
  output logic [3*NUM_ROADS-1:0]       light,
  output logic [$clog2(NUM_ROADS)-1:0] active_road,
  output logic [TIME_W-1:0]            time_left,
  output logic                         phase_start
);

  localparam int AW = $clog2(NUM_ROADS);
  localparam int GW = $clog2(MIN_GREEN + 1) + 1;
  localparam bit HAS_AR = (ALL_RED_T > 0);
  localparam logic [TIME_W-1:0] AR_LOAD = TIME_W'(ALL_RED_T);
  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED
  } state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_road;
  logic [TIME_W-1:0]      r_left;
  logic [GW-1:0]          r_gcnt;
  logic [3*NUM_ROADS-1:0] r_light;
  logic                   r_pstart;

  logic [AW-1:0]     w_next;
  logic              w_others;
  logic              w_rest;
  logic              w_gap;
  logic              w_last;
  logic [TIME_W-1:0] w_gload;
  logic [TIME_W-1:0] w_yload;

  function automatic logic [3*NUM_ROADS-1:0] lamps(
    input state_t        s,
    input logic [AW-1:0] rd
  );
    lamps = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (AW'(i) == rd && s == S_GREEN)
        lamps[3*i+2] = 1'b1;
      else if (AW'(i) == rd && s == S_YELLOW)
        lamps[3*i+1] = 1'b1;
      else
        lamps[3*i] = 1'b1;
    end
  endfunction

  // descending scan so the nearest road after r_road wins
  always_comb begin : next_sel
    logic [AW-1:0] k;
    w_next = '0;
    k      = '0;
    for (int i = NUM_ROADS - 1; i >= 1; i--) begin
      k = AW'((int'(r_road) + i) % NUM_ROADS);
      if (car[k]) w_next = k;
    end
  end

  assign w_others = |(car & ~(NUM_ROADS'(1) << r_road));
  assign w_rest   = (r_road == '0) && !w_others;
  assign w_gap    = !car[r_road] && w_others
                 && (int'(r_gcnt) + 1 >= MIN_GREEN);
  assign w_last   = (r_left <= ONE);
  assign w_gload  = (green_time == '0) ? ONE : green_time;
  assign w_yload  = (yellow_time == '0) ? ONE : yellow_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_ALLRED;
      r_road   <= '0;
      r_left   <= AR_LOAD;
      r_gcnt   <= '0;
      r_light  <= {NUM_ROADS{3'b001}};
      r_pstart <= 1'b0;
    end else begin
      r_pstart <= 1'b0;
      if (tick) begin
        unique case (r_state)
          S_GREEN: begin
            if (r_gcnt != GW'(MIN_GREEN))
              r_gcnt <= r_gcnt + 1'b1;
            if (w_rest && w_last) begin
              r_left <= ONE;
            end else if (w_gap || w_last) begin
              r_state  <= S_YELLOW;
              r_left   <= w_yload;
              r_light  <= lamps(S_YELLOW, r_road);
              r_pstart <= 1'b1;
            end else begin
              r_left <= r_left - 1'b1;
            end
          end
          S_YELLOW: begin
            if (w_last && HAS_AR) begin
              r_state  <= S_ALLRED;
              r_left   <= AR_LOAD;
              r_light  <= {NUM_ROADS{3'b001}};
              r_pstart <= 1'b1;
            end else if (w_last) begin
              r_state  <= S_GREEN;
              r_road   <= w_next;
              r_left   <= w_gload;
              r_gcnt   <= '0;
              r_light  <= lamps(S_GREEN, w_next);
              r_pstart <= 1'b1;
            end else begin
              r_left <= r_left - 1'b1;
            end
          end
          S_ALLRED: begin
            if (w_last) begin
              r_state  <= S_GREEN;
              r_road   <= w_next;
              r_left   <= w_gload;
              r_gcnt   <= '0;
              r_light  <= lamps(S_GREEN, w_next);
              r_pstart <= 1'b1;
            end else begin
              r_left <= r_left - 1'b1;
            end
          end
          default: r_state <= S_ALLRED;
        endcase
      end
    end
  end

  assign light       = r_light;
  assign active_road = r_road;
  assign time_left   = r_left;
  assign phase_start = r_pstart;

endmodule
